// File: rtl/stream_lane_pipe.sv
// Issue/retire controller between the read buffer and write buffer around a fixed-latency lane operator.
// Optional stall counters are enabled with `define STREAM_LANE_PIPE_STATS_EN.
module stream_lane_pipe #(
   parameter int unsigned LANES      = 2,
   parameter int unsigned LANE_W     = 32,
   parameter int unsigned LATENCY    = 4,
   parameter int unsigned SKID_DEPTH = 8,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clr,
   input  logic                      run,
   input  logic [CNT_W-1:0]          elem_count,
   output logic                      done,
   output logic                      busy,
   input  logic [LANES*LANE_W-1:0]   in_data,
   input  logic                      in_empty,
   output logic                      in_rd_en,
   output logic [LANES*LANE_W-1:0]   op_data,
   output logic                      op_valid,
   input  logic [LANES*LANE_W-1:0]   res_data,
   output logic [LANES*LANE_W-1:0]   out_data,
   output logic                      out_wr_en,
   input  logic                      out_afull
`ifdef STREAM_LANE_PIPE_STATS_EN
   ,
   output logic [31:0]               stall_in_cnt,
   output logic [31:0]               stall_out_cnt
`endif
);

   localparam int unsigned DW    = LANES * LANE_W;
   localparam int unsigned PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
   localparam int unsigned FC_W  = $clog2(SKID_DEPTH + 1);
   localparam int unsigned CR_W  = FC_W + 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             done_d;
   logic             start;
   logic             issue;
   logic             capture;
   logic             pop;
   logic [CNT_W-1:0] count_q, issued_q, written_q;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [FC_W-1:0]  fifo_cnt_q, inflight_q;
   logic [CR_W-1:0]  credit_used;
   logic [DW-1:0]    fifo_mem [SKID_DEPTH];

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(SKID_DEPTH - 1)) ? '0 : PTR_W'(p + 1'b1);
   endfunction

   // Results already in the FIFO plus results still inside the operator.
   assign credit_used = CR_W'(fifo_cnt_q) + CR_W'(inflight_q);
   assign pop         = !clr && (fifo_cnt_q != '0) && !out_afull;

   assign in_rd_en = issue;
   assign op_valid = issue;
   assign op_data  = in_data;

   // Next-state and issue decode.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      start   = 1'b0;
      issue   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               start = 1'b1;
               if (elem_count == '0) done_d  = 1'b1;
               else                  state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            issue = !in_empty && (issued_q < count_q) &&
                    (credit_used < CR_W'(SKID_DEPTH));
            if (issue && (CNT_W'(issued_q + 1'b1) == count_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (written_q == count_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clr) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
         start   = 1'b0;
         issue   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= done_d;
         busy    <= (state_d != S_IDLE);
      end
   end

   // Valid tracking: stage 0 is the issue strobe itself.
   generate
      if (LATENCY == 1) begin : g_lat1
         assign capture = issue;
      end else begin : g_vld
         logic [LATENCY-2:0] vld_q;
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               vld_q <= '0;
            end else if (clr) begin
               vld_q <= '0;
            end else begin
               vld_q[0] <= issue;
               for (int unsigned k = 1; k < LATENCY - 1; k++) vld_q[k] <= vld_q[k-1];
            end
         end
         assign capture = vld_q[LATENCY-2];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q    <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_data   <= '0;
         out_wr_en  <= 1'b0;
      end else if (clr) begin
         count_q    <= '0;
         issued_q   <= '0;
         written_q  <= '0;
         inflight_q <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         out_data   <= '0;
         out_wr_en  <= 1'b0;
      end else begin
         if (start) begin
            count_q   <= elem_count;
            issued_q  <= '0;
            written_q <= '0;
         end else begin
            if (issue) issued_q  <= CNT_W'(issued_q + 1'b1);
            if (pop)   written_q <= CNT_W'(written_q + 1'b1);
         end
         case ({issue, capture})
            2'b10:   inflight_q <= FC_W'(inflight_q + 1'b1);
            2'b01:   inflight_q <= FC_W'(inflight_q - 1'b1);
            default: inflight_q <= inflight_q;
         endcase
         case ({capture, pop})
            2'b10:   fifo_cnt_q <= FC_W'(fifo_cnt_q + 1'b1);
            2'b01:   fifo_cnt_q <= FC_W'(fifo_cnt_q - 1'b1);
            default: fifo_cnt_q <= fifo_cnt_q;
         endcase
         if (capture) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
            out_data <= fifo_mem[rd_ptr_q];
         end
         out_wr_en <= pop;
      end
   end

   // Skid storage; stale contents are harmless because the pointers are cleared.
   always_ff @(posedge clk) begin
      if (capture) fifo_mem[wr_ptr_q] <= res_data;
   end

`ifdef STREAM_LANE_PIPE_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_in_cnt  <= '0;
         stall_out_cnt <= '0;
      end else if (clr || start) begin
         stall_in_cnt  <= '0;
         stall_out_cnt <= '0;
      end else begin
         if ((state_q == S_ISSUE) && in_empty && (stall_in_cnt != '1))
            stall_in_cnt <= 32'(stall_in_cnt + 1'b1);
         if ((fifo_cnt_q != '0) && out_afull && (stall_out_cnt != '1))
            stall_out_cnt <= 32'(stall_out_cnt + 1'b1);
      end
   end
`endif

endmodule

// File: doc/stream_lane_pipe.md
Name: stream_lane_pipe

Overview:
- Parametrised issue/retire controller for the compute stage between the 512-to-64 read buffer and the 64-to-512 write buffer.
- Pops LANES*LANE_W-bit beats from the upstream buffer and presents them to an external fixed-latency lane operator (e.g. fp_mult_reg per lane).
- Tracks in-flight beats and captures results into an internal skid FIFO, so downstream backpressure never drops a result.
- Counts beats against a programmed length and pulses done when the last result has been handed downstream.

Parameters:
LANES, 2, number of LANE_W-bit lanes per beat
LANE_W, 32, lane width in bits
LATENCY, 4, operator latency in cycles from issue to result (≥1)
SKID_DEPTH, 8, result FIFO entries (≥1; ≥LATENCY+1 for full throughput)
CNT_W, 32, width of the beat counters

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous clear, active-high
run  in  1  start pulse
elem_count  in  CNT_W  beats to process, sampled on accepted run
done  out  1  one-cycle completion pulse
busy  out  1  high while not IDLE
in_data  in  LANES*LANE_W  upstream head beat (show-ahead)
in_empty  in  1  upstream empty
in_rd_en  out  1  upstream pop
op_data  out  LANES*LANE_W  operator operands
op_valid  out  1  operator issue strobe
res_data  in  LANES*LANE_W  operator result, valid LATENCY cycles after op_valid
out_data  out  LANES*LANE_W  downstream beat
out_wr_en  out  1  downstream push
out_afull  in  1  downstream cannot accept (high = stop)

Behaviour:
- Reset (rst=0, async): state IDLE; all counters, FIFO pointers and valid shift register cleared; done, busy, in_rd_en, op_valid, out_wr_en = 0; out_data = 0.
- clr=1: same clearing as reset, synchronous, takes priority over every other event; in-flight results are discarded.
- States: IDLE, ISSUE, DRAIN.
- IDLE: on run, latch elem_count, zero issued/retired/written counters. If elem_count=0, pulse done next cycle and stay IDLE. Otherwise go to ISSUE.
- ISSUE: issue = !in_empty && issued<count && (fifo_cnt+inflight)<SKID_DEPTH.
  - in_rd_en = op_valid = issue (combinational); op_data = in_data.
  - When issued reaches count, go to DRAIN.
- DRAIN: no issue. When written==count, pulse done for 1 cycle and go to IDLE.
- run while busy is ignored; elem_count is not re-sampled.
- Valid shift register, LATENCY stages: stage0 = issue. The beat is captured when stage LATENCY-1 is high on the rising edge; res_data is sampled into the FIFO tail at that edge.
- inflight: +1 on issue, −1 on capture; both in the same cycle leaves it unchanged.
- FIFO pop = fifo_cnt>0 && !out_afull. out_data/out_wr_en are registered, so the beat appears the cycle after pop; written increments with out_wr_en.
- Simultaneous FIFO push and pop: fifo_cnt is unchanged. The credit check guarantees a push never finds the FIFO full.
- Order is strictly preserved; no beat is duplicated or dropped.
- Counters wrap modulo 2^CNT_W. elem_count ≥ 2^CNT_W−1 is not supported.
- busy = (state≠IDLE).

Optional Feature:
STREAM_LANE_PIPE_STATS_EN
- Defined: adds outputs stall_in_cnt[31:0] and stall_out_cnt[31:0].
  - stall_in_cnt counts ISSUE cycles with in_empty=1.
  - stall_out_cnt counts cycles with fifo_cnt>0 && out_afull=1.
  - Both clear on accepted run, reset and clr; both saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Defaults, elem_count=8, in_empty=0, out_afull=0, run at cycle T → in_rd_en high cycles T+1..T+8; out_wr_en high T+1+LATENCY+1 .. T+8+LATENCY+1 with results in order; done pulse one cycle after the last out_wr_en; busy low afterwards.
- elem_count=20, out_afull=1 held → exactly SKID_DEPTH (8) pops, then in_rd_en stays 0. Release out_afull → all 20 results emerge in order, then done.
- elem_count=0, run → done high exactly one cycle after run; in_rd_en and out_wr_en never assert; busy stays 0.
- elem_count=6, in_empty toggling every other cycle → 6 pops only when in_empty=0; outputs in order with gaps; done after the 6th out_wr_en.
- Mid-run rst=0 asynchronously → outputs 0 before the next edge. Separately, clr=1 mid-run → IDLE next cycle, fifo empty, no further out_wr_en, no done.
- Second run during ISSUE with elem_count=3 → ignored; the original count completes and a single done pulse occurs.
